snoop_ac_queue: RTL
===================

Name: snoop_ac_queue

Overview:
- Upstream stage of the snoop cache controller. Buffers incoming ACE AC-channel snoop requests from the interconnect in a small FIFO.
- Issues them one at a time to the controller, and holds a request back while a flush is in progress or an AMO is in flight to the same cache line.
- Tracks the single outstanding snoop by observing the controller's CR handshake. Exports a busy indication.

Parameters:
- DEPTH, 2, number of AC request entries (power of two, >=2)
- ADDR_WIDTH, 64, snoop address width
- SNOOP_WIDTH, 4, ACSNOOP width
- PROT_WIDTH, 3, ACPROT width
- LINE_OFFSET, 4, byte-offset bits of a cache line (DCACHE_BYTE_OFFSET)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- ac_valid_i  in  1  upstream AC valid
- ac_ready_o  out  1  upstream AC ready
- ac_addr_i  in  ADDR_WIDTH  upstream snoop address
- ac_snoop_i  in  SNOOP_WIDTH  upstream snoop type
- ac_prot_i  in  PROT_WIDTH  upstream protection
- ac_valid_o  out  1  AC valid to controller
- ac_ready_i  in  1  AC ready from controller
- ac_addr_o  out  ADDR_WIDTH  head address
- ac_snoop_o  out  SNOOP_WIDTH  head snoop type
- ac_prot_o  out  PROT_WIDTH  head protection
- cr_valid_i  in  1  controller CR valid (observed only)
- cr_ready_i  in  1  interconnect CR ready (observed only)
- flushing_i  in  1  cache flush in progress
- amo_valid_i  in  1  AMO in flight
- amo_addr_i  in  ADDR_WIDTH  AMO address
- busy_o  out  1  queue non-empty or snoop outstanding
- level_o  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_ni is synchronous and active-low, sampled on the rising edge of clk_i.
  - Reset (including mid-operation) clears the FIFO, the presenting flag and the outstanding flag.
  - Reset values: ac_ready_o=1, ac_valid_o=0, busy_o=0, level_o=0. ac_addr_o, ac_snoop_o and ac_prot_o read 0 while empty.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits. Both wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - ac_ready_o = (count != DEPTH). Combinational, independent of ac_ready_i, so there is no push at full even if the head pops that cycle.
  - Push on ac_valid_i & ac_ready_o. Pop on ac_valid_o & ac_ready_i.
  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
- No fall-through: an entry written in cycle N can first drive ac_valid_o in cycle N+1. Minimum latency is 1 cycle.
- hold = flushing_i | (amo_valid_i & amo_addr_i[ADDR_WIDTH-1:LINE_OFFSET] == head_addr[ADDR_WIDTH-1:LINE_OFFSET]).
- Issue gating:
  - Not presenting: ac_valid_o = (count!=0) & !hold & !outstanding.
  - Once ac_valid_o is 1 without a handshake, the presenting flag is set and ac_valid_o stays 1 until ac_ready_i, regardless of hold. The head payload must not change while presenting.
- Outstanding flag:
  - Set on the AC handshake at the output.
  - Cleared on cr_valid_i & cr_ready_i.
  - If set and clear happen in the same cycle, set wins. This cannot happen legally, so the bench asserts it never occurs.
  - At most one snoop is in the controller at a time.
- busy_o = (count!=0) | outstanding | presenting.
- The block does no decoding of the snoop type. Unsupported types are forwarded; the controller returns the error response.

Test Plan:
- Reset, then single push: addr 0x8000_0040, snoop 0x1 -> ac_valid_o=1 in the next cycle with the same payload. ac_ready_i=1 -> level_o=0, busy_o=1 until the CR handshake, then 0.
- Fill with DEPTH=2: push 0x100 and 0x200 with ac_ready_i=0 -> ac_ready_o=0 and level_o=2. A third ac_valid_i is not accepted. Pop -> ac_ready_o=1 in the same cycle as count drops. Order preserved: 0x100, then 0x200.
- AMO collision: amo_valid_i=1 and amo_addr_i=0x1008, head at 0x1000 -> ac_valid_o=0. Drop amo_valid_i -> ac_valid_o=1 the next evaluation cycle. With amo_addr_i=0x1010 (a different line), the head issues immediately.
- Valid stability: ac_valid_o=1 with ac_ready_i=0, then raise flushing_i -> ac_valid_o stays 1 with the payload unchanged until ac_ready_i=1.
- Outstanding gating: queue 0x40 and 0x80. First issues. Second stays ac_valid_o=0 until cr_valid_i & cr_ready_i, then issues in the following cycle.
- Wrap and reset: 5 push/pop pairs with ac_ready_i held 1 -> payloads in order and pointers wrapped. Assert rst_ni=0 for one edge with level_o=1 -> level_o=0, ac_valid_o=0, busy_o=0 after that edge.

Source files
------------

// File: rtl/snoop_ac_queue.sv
// Snoop AC request queue: buffers AC requests, issues one at a time, gated by flush/AMO-line/outstanding.
// Latency >=1 cycle (no fall-through); ac_ready_o drops only at full, ac_valid_o holds until accepted.
module snoop_ac_queue #(
  parameter int DEPTH       = 2,
  parameter int ADDR_WIDTH  = 64,
  parameter int SNOOP_WIDTH = 4,
  parameter int PROT_WIDTH  = 3,
  parameter int LINE_OFFSET = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [ADDR_WIDTH-1:0]        ac_addr_i,
  input  logic [SNOOP_WIDTH-1:0]       ac_snoop_i,
  input  logic [PROT_WIDTH-1:0]        ac_prot_i,
  output logic                         ac_valid_o,
  input  logic                         ac_ready_i,
  output logic [ADDR_WIDTH-1:0]        ac_addr_o,
  output logic [SNOOP_WIDTH-1:0]       ac_snoop_o,
  output logic [PROT_WIDTH-1:0]        ac_prot_o,
  input  logic                         cr_valid_i,
  input  logic                         cr_ready_i,
  input  logic                         flushing_i,
  input  logic                         amo_valid_i,
  input  logic [ADDR_WIDTH-1:0]        amo_addr_i,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [SNOOP_WIDTH-1:0] snoop;
    logic [PROT_WIDTH-1:0]  prot;
  } ac_req_t;

  ac_req_t         mem [DEPTH];
  ac_req_t         head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            presenting;
  logic            outstanding;
  logic            not_empty;
  logic            hold;
  logic            push;
  logic            pop;
  logic            cr_hs;

  assign not_empty = (count != '0);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  // Same cache line as an in-flight AMO, compared above the line offset.
  assign hold = flushing_i |
                (amo_valid_i &
                 (amo_addr_i[ADDR_WIDTH-1:LINE_OFFSET] == head.addr[ADDR_WIDTH-1:LINE_OFFSET]));

  assign ac_ready_o = (count != FULL);
  assign ac_valid_o = presenting | (not_empty & ~hold & ~outstanding);
  assign push       = ac_valid_i & ac_ready_o;
  assign pop        = ac_valid_o & ac_ready_i;
  assign cr_hs      = cr_valid_i & cr_ready_i;

  assign ac_addr_o  = head.addr;
  assign ac_snoop_o = head.snoop;
  assign ac_prot_o  = head.prot;
  assign busy_o     = not_empty | outstanding | presenting;
  assign level_o    = count;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {ac_addr_i, ac_snoop_i, ac_prot_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      presenting  <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      // Once offered, the request stays offered until the controller takes it.
      if (pop) begin
        presenting <= 1'b0;
      end else if (ac_valid_o) begin
        presenting <= 1'b1;
      end
      if (pop) begin
        outstanding <= 1'b1;
      end else if (cr_hs) begin
        outstanding <= 1'b0;
      end
    end
  end

endmodule
